// File: rtl/spw_light_time_ctrl.sv
// SpaceWire time-code transmit controller: manual and periodic auto ticks.
// Optional receive capture of time-codes is enabled by SPW_TIME_RX_CAPTURE_EN.
module spw_light_time_ctrl #(
  parameter int DIV_W = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        link_running,
  input  logic        tick_out,
  input  logic [7:0]  time_out,
  output logic        tick_in,
  output logic [7:0]  time_in
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  state_t           state;
  logic [1:0]       gap_cnt;
  logic [7:0]       l;
  logic [7:0]       m;
  logic             mp;
  logic             ap;
  logic             auto_en;
  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] cnt;
  logic             rxv;
  logic [7:0]       r;

  logic       wr_en;
  logic       wr_time;
  logic       wr_ctrl;
  logic       wr_period;
  logic       run;
  logic       expire;
  logic       decide;
  logic       take_man;
  logic       take_auto;
  logic       launch;
  logic [7:0] auto_code;
  logic [7:0] sel_code;
  logic       unused;

  assign wr_en     = chipselect & ~write_n;
  assign wr_time   = wr_en & (address == 2'd0);
  assign wr_ctrl   = wr_en & (address == 2'd1);
  assign wr_period = wr_en & (address == 2'd2);

  assign run    = auto_en & (period != '0);
  assign expire = run & (cnt == CNT_ONE);

  // The last gap cycle doubles as the idle decision so ticks can be 4 apart.
  assign decide    = (state == IDLE) | ((state == GAP) & (gap_cnt == 2'd0));
  assign take_man  = decide & link_running & mp;
  assign take_auto = decide & link_running & ap & ~mp;
  assign launch    = take_man | take_auto;
  assign auto_code = {l[7:6], l[5:0] + 6'd1};
  assign sel_code  = mp ? m : auto_code;

  // time_in always mirrors the last code sent, including during the pulse.
  assign time_in = l;

  assign unused = ^{writedata, tick_out, time_out};

  // Transmit sequencer: one-cycle tick pulse followed by a 3-cycle gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= 2'd0;
      tick_in <= 1'b0;
      l       <= 8'h00;
    end else begin
      case (state)
        SEND: begin
          tick_in <= 1'b0;
          gap_cnt <= 2'd2;
          state   <= GAP;
        end
        default: begin
          if ((state == GAP) && (gap_cnt != 2'd0)) begin
            gap_cnt <= gap_cnt - 2'd1;
          end else if (launch) begin
            tick_in <= 1'b1;
            l       <= sel_code;
            state   <= SEND;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Host registers, pending flags and the auto-tick down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      m       <= 8'h00;
      mp      <= 1'b0;
      ap      <= 1'b0;
      auto_en <= 1'b0;
      period  <= '0;
      cnt     <= '0;
    end else begin
      if (wr_time) begin
        m  <= writedata[7:0];
        mp <= 1'b1;
      end else if (take_man) begin
        mp <= 1'b0;
      end
      if (wr_ctrl) begin
        auto_en <= writedata[0];
      end
      if (wr_period) begin
        period <= writedata[DIV_W-1:0];
        cnt    <= writedata[DIV_W-1:0];
      end else if (run) begin
        cnt <= (cnt <= CNT_ONE) ? period : cnt - CNT_ONE;
      end
      if (expire) begin
        ap <= 1'b1;
      end else if (take_auto || !auto_en) begin
        ap <= 1'b0;
      end
    end
  end

`ifdef SPW_TIME_RX_CAPTURE_EN
  // Received time-code capture; a new code beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r   <= 8'h00;
      rxv <= 1'b0;
    end else if (tick_out) begin
      r   <= time_out;
      rxv <= 1'b1;
    end else if (wr_ctrl && writedata[1]) begin
      rxv <= 1'b0;
    end
  end
`else
  assign r   = 8'h00;
  assign rxv = 1'b0;
`endif

  // Zero-wait-state register read mux.
  always_comb begin
    readdata = 32'h0;
    unique case (address)
      2'd0: readdata = {24'h0, l};
      2'd1: readdata = {31'h0, auto_en};
      2'd2: readdata = 32'(period);
      2'd3: readdata = {16'h0, r, 4'h0, link_running, rxv, ap, mp};
      default: readdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_spw_light_time_ctrl.sv
// Scoreboard bench for spw_light_time_ctrl: queued expected ticks and reads,
// checked by a monitor on the falling edge.
module tb_spw_light_time_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        link_running;
  logic        tick_out;
  logic [7:0]  time_out;
  logic        tick_in;
  logic [7:0]  time_in;

  typedef struct {
    logic [7:0] code;
    int         gap;
  } tk_t;

  typedef struct {
    string       nm;
    logic [31:0] v;
  } rd_t;

  tk_t tk_q[$];
  rd_t rd_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_tick = 0;
  logic prev_tick = 1'b0;
  logic rd_req = 1'b0;

  spw_light_time_ctrl #(.DIV_W(24)) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .link_running(link_running),
    .tick_out(tick_out),
    .time_out(time_out),
    .tick_in(tick_in),
    .time_in(time_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected reads and ticks as the DUT presents them.
  always @(negedge clk) begin
    if (rd_req) begin
      rd_t e;
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_noexp got %h", readdata);
      end else begin
        e = rd_q.pop_front();
        if (readdata !== e.v) begin
          errors++;
          $display("FAIL %s got %h want %h", e.nm, readdata, e.v);
        end
      end
    end
    if (tick_in === 1'b1) begin
      tk_t t;
      checks++;
      if (prev_tick) begin
        errors++;
        $display("FAIL tick_width got 2+ cycles want 1");
      end
      checks++;
      if (tk_q.size() == 0) begin
        errors++;
        $display("FAIL tick_unexpected got %h want none", time_in);
      end else begin
        t = tk_q.pop_front();
        if (time_in !== t.code) begin
          errors++;
          $display("FAIL tick_code got %h want %h", time_in, t.code);
        end
        if (t.gap != 0) begin
          checks++;
          if (cyc - last_tick != t.gap) begin
            errors++;
            $display("FAIL tick_gap got %0d want %0d",
                     cyc - last_tick, t.gap);
          end
        end
      end
      last_tick = cyc;
    end
    prev_tick = (tick_in === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input string nm,
                    input logic [31:0] v);
    rd_t e;
    e.nm = nm;
    e.v  = v;
    rd_q.push_back(e);
    address = a;
    rd_req  = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  task automatic exp_tick(input logic [7:0] code, input int gap);
    tk_t t;
    t.code = code;
    t.gap  = gap;
    tk_q.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  logic [31:0] rx1;
  logic [31:0] rx2;
  logic [31:0] rx3;

  initial begin
`ifdef SPW_TIME_RX_CAPTURE_EN
    rx1 = 32'h9A0C;
    rx2 = 32'h9A08;
    rx3 = 32'h550C;
`else
    rx1 = 32'h0008;
    rx2 = 32'h0008;
    rx3 = 32'h0008;
`endif
    reset        = 1'b1;
    address      = 2'd0;
    chipselect   = 1'b0;
    write_n      = 1'b1;
    writedata    = 32'h0;
    link_running = 1'b0;
    tick_out     = 1'b0;
    time_out     = 8'h00;
    wait_cyc(3);
    reset = 1'b0;

    chk("rst_tick_in", {31'h0, tick_in}, 32'h0);
    chk("rst_time_in", {24'h0, time_in}, 32'h0);
    rd(2'd0, "rst_time", 32'h0);
    rd(2'd1, "rst_ctrl", 32'h0);
    rd(2'd2, "rst_period", 32'h0);
    rd(2'd3, "rst_status", 32'h0);

    link_running = 1'b1;
    exp_tick(8'h45, 0);
    wr(2'd0, 32'h45);
    wait_cyc(8);
    rd(2'd0, "time_45", 32'h45);

    exp_tick(8'h3E, 0);
    wr(2'd0, 32'h3E);
    wait_cyc(8);
    exp_tick(8'h3F, 0);
    exp_tick(8'h00, 10);
    exp_tick(8'h01, 10);
    wr(2'd2, 32'd10);
    wr(2'd1, 32'h1);
    wait_cyc(35);
    wr(2'd1, 32'h0);
    wait_cyc(20);
    rd(2'd0, "time_wrap", 32'h01);

    link_running = 1'b0;
    wr(2'd0, 32'h12);
    wr(2'd0, 32'h13);
    wait_cyc(10);
    rd(2'd3, "status_mp", 32'h1);
    exp_tick(8'h13, 0);
    link_running = 1'b1;
    wait_cyc(8);
    rd(2'd0, "time_13", 32'h13);

    link_running = 1'b0;
    wr(2'd2, 32'd200);
    wr(2'd1, 32'h1);
    wait_cyc(205);
    wr(2'd0, 32'h07);
    rd(2'd3, "status_mp_ap", 32'h3);
    exp_tick(8'h07, 0);
    exp_tick(8'h08, 4);
    link_running = 1'b1;
    wait_cyc(15);
    wr(2'd1, 32'h0);
    step();
    rd(2'd3, "status_idle", 32'h8);

    exp_tick(8'hBF, 0);
    wr(2'd0, 32'hBF);
    wait_cyc(8);
    exp_tick(8'h80, 0);
    wr(2'd2, 32'd5);
    wr(2'd1, 32'h1);
    wait_cyc(6);
    wr(2'd1, 32'h0);
    rd(2'd2, "period_5", 32'd5);
    rd(2'd1, "ctrl_off", 32'h0);
    wait_cyc(12);
    rd(2'd0, "time_80", 32'h80);

    tick_out = 1'b1;
    time_out = 8'h9A;
    step();
    tick_out = 1'b0;
    rd(2'd3, "status_rx", rx1);
    wr(2'd1, 32'h2);
    rd(2'd3, "status_rxclr", rx2);
    tick_out = 1'b1;
    time_out = 8'h55;
    wr(2'd1, 32'h2);
    tick_out = 1'b0;
    rd(2'd3, "status_rxwin", rx3);

    exp_tick(8'h21, 0);
    wr(2'd0, 32'h21);
    step();
    wr(2'd0, 32'h33);
    reset = 1'b1;
    step();
    chk("abort_tick_in", {31'h0, tick_in}, 32'h0);
    chk("abort_time_in", {24'h0, time_in}, 32'h0);
    reset = 1'b0;
    wait_cyc(12);
    rd(2'd0, "abort_time", 32'h0);
    rd(2'd3, "abort_status", 32'h8);
    wait_cyc(2);

    checks++;
    if (tk_q.size() != 0) begin
      errors++;
      $display("FAIL tick_missing got %0d left want 0", tk_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
